// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: MemOps, FSM states, owners,
// plus the op-legality helper used when an LSU request is accepted.
package dmem_arbiter_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Encodings with no access size, or an unsigned variant used for a store.
  function automatic logic memop_illegal(logic [2:0] op, logic wen);
    logic bad_enc;
    bad_enc = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    return bad_enc || (wen && ((op == MEMOP_BU) || (op == MEMOP_HU)));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester (IFU, LSU) and memory-side handshake bundle for dmem_arbiter.
// The arbiter uses the slave view; requesters/memory models use master.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid, ifu_resp_ready;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_err;

  logic          lsu_req_valid, lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [2:0]    lsu_memop;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_resp_valid, lsu_resp_ready;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;

  logic            mem_req_valid, mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dmem_arbiter_lane_align.sv
// Byte-lane steering for a 32-bit little-endian port: store mask/data
// placement, load extraction with sign/zero extension, alignment check.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0]  memop_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sx;

  // Replicating narrow store data puts it in every lane; the mask picks one.
  always_comb begin
    wmask_o    = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (memop_i[1:0])
      2'b00: begin
        wmask_o = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wmask_o    = 4'b0011 << addr_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      2'b10: begin
        wmask_o    = 4'b1111;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = rdata_i[{addr_i, 3'b000} +: 8];
    lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sx     = !memop_i[2];
    case (memop_i[1:0])
      2'b00:   rdata_o = {{24{sx & lane_b[7]}}, lane_b};
      2'b01:   rdata_o = {{16{sx & lane_h[15]}}, lane_h};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharer of one data-memory port between IFU and LSU, one
// transaction in flight; illegal requests are answered locally with err.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  owner_e        owner_q, last_grant_q;
  logic [AW-1:0] addr_q;
  logic          wen_q;
  logic [2:0]    memop_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic       grant_lsu, grant_ifu, idle, acc_lsu, acc_ifu, accept, acc_err;
  logic       resp_hs, in_req, in_resp, st_mem;
  logic [2:0] al_memop;
  logic [1:0] al_addr;
  logic [3:0] al_wmask;
  logic [31:0] al_wdata, al_rdata;
  logic       al_misalign;

  assign grant_lsu = bus.lsu_req_valid & (!bus.ifu_req_valid | (last_grant_q == OWN_IFU));
  assign grant_ifu = bus.ifu_req_valid & !grant_lsu;
  // Readies are forced low while reset is asserted so every output reads 0.
  assign idle      = (state_q == ST_IDLE) & rst_n;
  assign acc_lsu   = idle & grant_lsu;
  assign acc_ifu   = idle & grant_ifu;
  assign accept    = acc_lsu | acc_ifu;

  // In IDLE the aligner checks the live LSU request; afterwards it works on
  // the captured transaction.
  assign al_memop = (state_q == ST_IDLE) ? bus.lsu_memop     : memop_q;
  assign al_addr  = (state_q == ST_IDLE) ? bus.lsu_addr[1:0] : addr_q[1:0];

  dmem_lane_align u_align (
    .memop_i    (al_memop),
    .addr_i     (al_addr),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata_q),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  assign acc_err = acc_lsu ? (al_misalign | memop_illegal(bus.lsu_memop, bus.lsu_wen))
                           : (|bus.ifu_addr[1:0]);
  assign resp_hs = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)             state_d = acc_err ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.mem_req_ready)  state_d = ST_WAIT;
      ST_WAIT: if (bus.mem_resp_valid) state_d = ST_RESP;
      ST_RESP: if (resp_hs)            state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      memop_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= acc_lsu ? OWN_LSU : OWN_IFU;
        last_grant_q <= acc_lsu ? OWN_LSU : OWN_IFU;
        addr_q       <= acc_lsu ? bus.lsu_addr : bus.ifu_addr;
        wen_q        <= acc_lsu & bus.lsu_wen;
        memop_q      <= acc_lsu ? bus.lsu_memop : MEMOP_W;
        wdata_q      <= acc_lsu ? bus.lsu_wdata : '0;
        rdata_q      <= '0;
        err_q        <= acc_err;
      end
      if ((state_q == ST_WAIT) && bus.mem_resp_valid) rdata_q <= bus.mem_rdata;
    end
  end

  assign in_req  = (state_q == ST_REQ);
  assign in_resp = (state_q == ST_RESP);
  assign st_mem  = in_req & wen_q;

  assign bus.ifu_req_ready = acc_ifu;
  assign bus.lsu_req_ready = acc_lsu;

  assign bus.mem_req_valid = in_req;
  assign bus.mem_addr      = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
  assign bus.mem_wen       = st_mem;
  assign bus.mem_wdata     = st_mem ? al_wdata : '0;
  assign bus.mem_wmask     = st_mem ? al_wmask : '0;

  assign bus.ifu_resp_valid = in_resp & (owner_q == OWN_IFU);
  assign bus.ifu_err        = bus.ifu_resp_valid & err_q;
  assign bus.ifu_rdata      = (bus.ifu_resp_valid & !err_q) ? rdata_q : '0;

  assign bus.lsu_resp_valid = in_resp & (owner_q == OWN_LSU);
  assign bus.lsu_err        = bus.lsu_resp_valid & err_q;
  assign bus.lsu_rdata      = (bus.lsu_resp_valid & !err_q & !wen_q) ? al_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/arbitration sequences
// and random transactions scored against a byte-level reference model.
module tb_dmem_arbiter;

  typedef struct packed {
    bit          err;
    logic [31:0] maddr;
    bit          wen;
    logic [3:0]  wmask;
    logic [31:0] wdm;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    bit          lsu;
    logic [31:0] addr;
    bit          wen;
    logic [2:0]  op;
    logic [31:0] wd;
    logic [31:0] mw;
    logic [3:0]  rqw;
    logic [3:0]  rsw;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    bit          timeout, saw_mem, unstable, bad_grant, other;
    logic [31:0] maddr;
    bit          mwen;
    logic [31:0] mwdata;
    logic [3:0]  mwmask;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] lat;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [139:0] outs();
    return {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.ifu_rdata,
            bus.ifu_err, bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err,
            bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
  endfunction

  function automatic bit own_rv(bit lsu);
    return lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid;
  endfunction

  function automatic bit oth_rv(bit lsu);
    return lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid;
  endfunction

  function automatic logic [31:0] expand(logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Reference: access size/signedness from the op, then byte-by-byte placement.
  function automatic exp_t model(bit lsu, logic [31:0] a, bit wen, logic [2:0] op,
                                 logic [31:0] wd, logic [31:0] mw);
    exp_t e;
    int off, sz;
    bit uns, bad;
    logic [31:0] v;
    e = '0; off = int'(a % 4); sz = 4; uns = 0; bad = 0;
    if (lsu) begin
      case (op)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        3'd4: begin sz = 1; uns = 1; end
        3'd5: begin sz = 2; uns = 1; end
        default: bad = 1;
      endcase
      if (wen && uns) bad = 1;
    end
    if (off % sz != 0) bad = 1;
    e.err   = bad;
    e.maddr = a - 32'(off);
    if (bad) return e;
    if (!lsu) begin
      e.rdata = mw;
      return e;
    end
    if (wen) begin
      e.wen = 1;
      for (int i = 0; i < sz; i++) begin
        e.wmask[off+i] = 1'b1;
        e.wdm[8*(off+i) +: 8] = wd[8*i +: 8];
      end
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mw[8*(off+i) +: 8];
      if (!uns && sz < 4 && v[8*sz-1])
        for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
      e.rdata = v;
    end
    return e;
  endfunction

  function automatic vec_t mk(bit lsu, logic [31:0] a, bit wen, logic [2:0] op, logic [31:0] wd,
                              logic [31:0] mw, int rqw, int rsw, bit err, logic [31:0] maddr,
                              bit ewen, logic [3:0] wmask, logic [31:0] wdm, logic [31:0] rd);
    vec_t v;
    v.lsu = lsu; v.addr = a; v.wen = wen; v.op = op; v.wd = wd; v.mw = mw;
    v.rqw = 4'(rqw); v.rsw = 4'(rsw);
    v.e.err = err; v.e.maddr = maddr; v.e.wen = ewen; v.e.wmask = wmask;
    v.e.wdm = wdm; v.e.rdata = rd;
    return v;
  endfunction

  // One full transaction acting as requester and memory; records what was seen.
  task automatic run_txn(input bit lsu, input logic [31:0] a, input bit wen, input logic [2:0] op,
                         input logic [31:0] wd, input logic [31:0] mw, input int rqw,
                         input int rsw, output obs_t o);
    int n, c0;
    logic [68:0] snap;
    logic [32:0] rsnap;
    o = '0;
    @(negedge clk);
    if (lsu) begin
      bus.lsu_req_valid = 1; bus.lsu_addr = a; bus.lsu_wen = wen;
      bus.lsu_memop = op; bus.lsu_wdata = wd;
    end else begin
      bus.ifu_req_valid = 1; bus.ifu_addr = a;
    end
    #1; n = 0;
    while (!(lsu ? bus.lsu_req_ready : bus.ifu_req_ready)) begin
      if (n == 20) begin
        o.timeout = 1; bus.lsu_req_valid = 0; bus.ifu_req_valid = 0;
        return;
      end
      @(negedge clk); #1; n++;
    end
    c0 = cyc;
    @(posedge clk); #1;
    bus.lsu_req_valid = 0; bus.ifu_req_valid = 0;
    bus.lsu_addr = $urandom; bus.ifu_addr = $urandom; bus.lsu_wdata = $urandom;
    bus.lsu_memop = 3'($urandom_range(0, 7)); bus.lsu_wen = 1'($urandom_range(0, 1));
    n = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && !own_rv(lsu) && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) begin o.timeout = 1; return; end
    if (bus.mem_req_valid) begin
      o.saw_mem = 1; o.maddr = bus.mem_addr; o.mwen = bus.mem_wen;
      o.mwdata = bus.mem_wdata; o.mwmask = bus.mem_wmask;
      snap = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
      for (int i = 0; i < rqw; i++) begin
        @(negedge clk);
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== snap || !bus.mem_req_valid)
          o.unstable = 1;
      end
      bus.mem_req_ready = 1;
      @(posedge clk); #1 bus.mem_req_ready = 0;
      @(negedge clk);
      if (bus.mem_req_valid || own_rv(lsu)) o.unstable = 1;
      bus.mem_resp_valid = 1; bus.mem_rdata = mw;
      @(posedge clk); #1 bus.mem_resp_valid = 0; bus.mem_rdata = $urandom;
      @(negedge clk);
      if (!own_rv(lsu)) begin o.timeout = 1; return; end
    end
    o.lat   = 32'(cyc - c0);
    o.rdata = lsu ? bus.lsu_rdata : bus.ifu_rdata;
    o.err   = lsu ? bus.lsu_err : bus.ifu_err;
    rsnap   = {o.err, o.rdata};
    // The other requester knocks while we hold the response; it must wait.
    if (lsu) begin bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000; end
    else bus.lsu_req_valid = 1;
    for (int i = 0; i <= rsw; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.ifu_req_ready || bus.lsu_req_ready) o.bad_grant = 1;
      if (oth_rv(lsu)) o.other = 1;
      if (!own_rv(lsu) || rsnap !== (lsu ? {bus.lsu_err, bus.lsu_rdata} : {bus.ifu_err, bus.ifu_rdata}))
        o.unstable = 1;
    end
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    if (lsu) bus.lsu_resp_ready = 1; else bus.ifu_resp_ready = 1;
    @(posedge clk); #1 bus.lsu_resp_ready = 0; bus.ifu_resp_ready = 0;
    @(negedge clk);
    if (own_rv(lsu)) o.unstable = 1;
  endtask

  task automatic score(input string t, input obs_t o, input exp_t e, input int rqw);
    check({t, ".timeout"}, 32'(o.timeout), 0);
    check({t, ".err"}, 32'(o.err), 32'(e.err));
    check({t, ".memreq"}, 32'(o.saw_mem), 32'(!e.err));
    if (!e.err) begin
      check({t, ".maddr"}, o.maddr, e.maddr);
      check({t, ".wen"}, 32'(o.mwen), 32'(e.wen));
      check({t, ".wmask"}, 32'(o.mwmask), 32'(e.wmask));
      check({t, ".wdata"}, o.mwdata & expand(e.wmask), e.wdm);
    end
    check({t, ".rdata"}, o.rdata, e.rdata);
    check({t, ".lat"}, o.lat, e.err ? 32'd1 : 32'(3 + rqw));
    check({t, ".proto"}, {29'b0, o.unstable, o.bad_grant, o.other}, 0);
  endtask

  vec_t vt[16];
  obs_t ob;
  int   g[$];
  bit   pend;

  initial begin
    vt[0]  = mk(1, 32'h8000_0003, 0, 3'd0, 0, 32'h80FF_1234, 0, 0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'hFFFF_FF80);
    vt[1]  = mk(1, 32'h8000_0003, 0, 3'd4, 0, 32'h80FF_1234, 0, 0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h0000_0080);
    vt[2]  = mk(1, 32'h8000_0002, 1, 3'd1, 32'h0000_BEEF, 32'h5555_5555, 0, 0, 0, 32'h8000_0000, 1, 4'hC, 32'hBEEF_0000, 0);
    vt[3]  = mk(1, 32'h8000_0006, 0, 3'd2, 0, 32'h1111_1111, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    vt[4]  = mk(1, 32'h8000_0000, 0, 3'd3, 0, 32'h1111_1111, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    vt[5]  = mk(1, 32'h8000_0004, 0, 3'd2, 0, 32'hDEAD_BEEF, 5, 3, 0, 32'h8000_0004, 0, 4'h0, 0, 32'hDEAD_BEEF);
    vt[6]  = mk(1, 32'h8000_0002, 0, 3'd1, 0, 32'h80FF_1234, 1, 0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'hFFFF_80FF);
    vt[7]  = mk(1, 32'h8000_0000, 0, 3'd5, 0, 32'h80FF_1234, 0, 1, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h0000_1234);
    vt[8]  = mk(1, 32'h8000_0001, 1, 3'd0, 32'h0000_00A5, 0, 0, 0, 0, 32'h8000_0000, 1, 4'h2, 32'h0000_A500, 0);
    vt[9]  = mk(1, 32'h8000_0008, 1, 3'd2, 32'h1234_5678, 0, 2, 2, 0, 32'h8000_0008, 1, 4'hF, 32'h1234_5678, 0);
    vt[10] = mk(0, 32'h8000_0010, 0, 3'd0, 0, 32'hCAFE_F00D, 0, 0, 0, 32'h8000_0010, 0, 4'h0, 0, 32'hCAFE_F00D);
    vt[11] = mk(0, 32'h8000_0002, 0, 3'd0, 0, 32'hCAFE_F00D, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    vt[12] = mk(1, 32'h8000_0000, 1, 3'd4, 32'h55, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    vt[13] = mk(1, 32'h8000_0001, 0, 3'd1, 0, 32'h1234_5678, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    vt[14] = mk(1, 32'h8000_0007, 0, 3'd0, 0, 32'h7F00_0000, 0, 0, 0, 32'h8000_0004, 0, 4'h0, 0, 32'h0000_007F);
    vt[15] = mk(1, 32'h8000_000A, 0, 3'd5, 0, 32'hF00D_1234, 0, 0, 0, 32'h8000_0008, 0, 4'h0, 0, 32'h0000_F00D);

    bus.ifu_req_valid = 0; bus.ifu_addr = 0; bus.ifu_resp_ready = 0;
    bus.lsu_req_valid = 1; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_memop = 0;
    bus.lsu_wdata = 0; bus.lsu_resp_ready = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;
    rst_n = 0;
    bus.ifu_req_valid = 1;
    #2 check("reset.outs_ones", 32'($countones(outs())), 0);
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle.outs_ones", 32'($countones(outs())), 0);

    for (int i = 0; i < 16; i++) begin
      run_txn(vt[i].lsu, vt[i].addr, vt[i].wen, vt[i].op, vt[i].wd, vt[i].mw,
              int'(vt[i].rqw), int'(vt[i].rsw), ob);
      score($sformatf("vec%0d", i), ob, vt[i].e, int'(vt[i].rqw));
    end

    // Asynchronous reset while the LSU read is waiting on memory.
    @(negedge clk);
    bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_0004; bus.lsu_wen = 0; bus.lsu_memop = 3'd2;
    #1 check("rstw.accept", 32'(bus.lsu_req_ready), 1);
    @(posedge clk); #1 bus.lsu_req_valid = 0;
    @(negedge clk);
    check("rstw.memreq", 32'(bus.mem_req_valid), 1);
    bus.mem_req_ready = 1;
    @(posedge clk); #1 bus.mem_req_ready = 0;
    #2 rst_n = 0;
    #1 check("rstw.outs_ones", 32'($countones(outs())), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_txn(0, 32'h8000_0000, 0, 3'd0, 0, 32'h1357_9BDF, 0, 0, ob);
    score("rstw.ifu", ob, model(0, 32'h8000_0000, 0, 3'd0, 0, 32'h1357_9BDF), 0);

    // Both requesters continuously valid: last grant went to IFU, so LSU leads.
    @(negedge clk);
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000;
    bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_0004; bus.lsu_wen = 0; bus.lsu_memop = 3'd2;
    bus.mem_req_ready = 1; bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
    pend = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (g.size() >= 4) begin bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; end
      bus.mem_resp_valid = pend; pend = 0;
      #1;
      if (bus.lsu_req_ready) g.push_back(1);
      if (bus.ifu_req_ready) g.push_back(0);
      if (bus.mem_req_valid) pend = 1;
    end
    bus.mem_req_ready = 0; bus.ifu_resp_ready = 0; bus.lsu_resp_ready = 0; bus.mem_resp_valid = 0;
    check("arb.count", 32'(g.size()), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb.grant%0d_lsu", i), (i < g.size()) ? 32'(g[i]) : 32'd2, 32'((i % 2) == 0));

    for (int k = 0; k < 40; k++) begin
      bit          rl, rw;
      logic [2:0]  rop;
      logic [31:0] ra, rwd, rmw;
      int          q, s;
      rl  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      ra  = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      rwd = $urandom; rmw = $urandom;
      q   = $urandom_range(0, 2); s = $urandom_range(0, 2);
      run_txn(rl, ra, rw, rop, rwd, rmw, q, s, ob);
      score($sformatf("rnd%0d", k), ob, model(rl, ra, rw, rop, rwd, rmw), q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
